wm_read_arbiter: RTL and testbench
==================================

// Module: wm_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing one weight-memory read port among NUM_REQ conv unit control units.
//  Each requester asks for a burst of BURST_LEN consecutive words (one K x K kernel) starting at its own base address.
//  The arbiter grants one requester at a time and drives the memory port for the whole burst.
//  It returns read data tagged to the owner, delayed by the memory read latency.
//  Sits between the per-unit conv CUs and the single-port weight BRAM of a conv layer.
// PARAMETERS
//  NUM_REQ      3   number of requesting conv units (>=2)
//  ADDR_W       14  weight memory address width
//  DATA_WIDTH   32  weight word width
//  BURST_LEN    25  words per burst (KERNAL_SIZE*KERNAL_SIZE), >=2
//  MEM_LATENCY  1   cycles from mem_en/mem_addr to valid mem_rdata (>=1)
// PORTS
//  clk        in   1                 clock, rising edge
//  reset      in   1                 asynchronous, active-high
//  req        in   NUM_REQ           per-unit burst request, level
//  req_base   in   NUM_REQ*ADDR_W    per-unit burst start address; unit i at [i*ADDR_W +: ADDR_W]
//  pause      in   1                 freeze the current burst (downstream FIFO full / HOLD)
//  gnt        out  NUM_REQ           one-hot owner of current burst, 0 when idle
//  busy       out  1                 burst in progress (state==BURST)
//  mem_en     out  1                 memory read enable
//  mem_addr   out  ADDR_W            memory read address
//  mem_rdata  in   DATA_WIDTH        memory read data
//  rd_valid   out  NUM_REQ           one-hot: rd_data valid for that unit
//  rd_data    out  DATA_WIDTH        returned word (mem_rdata passed through)
//  rd_last    out  1                 qualifies final beat of a burst
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, busy=0, mem_en=0, mem_addr=0, rd_valid=0, rd_last=0.
//   Priority pointer last_winner=NUM_REQ-1, so unit 0 wins first. Latency pipeline cleared.
//  FSM: IDLE, BURST.
//  IDLE:
//   - If req!=0 at a clock edge, select the first set bit searching upward from last_winner+1 (mod NUM_REQ).
//   - Registered on that edge: gnt<=onehot(winner), last_winner<=winner, addr_reg<=req_base[winner], beat<=0, state<=BURST.
//   - req==0: remain in IDLE; outputs stay 0.
//  BURST:
//   - mem_en = ~pause (combinational); mem_addr = addr_reg+beat, modulo 2^ADDR_W (wraps, no error).
//   - Each cycle with ~pause, beat increments.
//   - Beat BURST_LEN-1 issued with ~pause: state<=IDLE, gnt<=0 on that edge.
//     At least one IDLE cycle follows between bursts.
//   - pause=1: mem_en=0, beat and addr frozen, gnt held; the burst resumes exactly where it stopped.
//  Request rules:
//   - req is sampled only in IDLE.
//   - Deasserting req mid-burst does not abort the burst.
//   - req_base is captured only at grant.
//  Return path: {mem_en, owner one-hot, beat==BURST_LEN-1} delayed MEM_LATENCY cycles.
//   - rd_valid = delayed mem_en & delayed owner; rd_last = delayed last-beat & delayed mem_en.
//   - rd_data = mem_rdata, unregistered.
//   - Exactly BURST_LEN rd_valid pulses per grant, with rd_last on the final one only.
//  Fairness: a continuously requesting unit waits at most NUM_REQ-1 bursts.
//  Simultaneous requests: the round-robin order decides; the lowest index wins only when the pointer is at NUM_REQ-1.
//  Reset mid-burst:
//   - Immediate abort; all outputs and the pipeline go to 0.
//   - No rd_valid emerges from beats in flight; the pointer returns to NUM_REQ-1.
//  rd_valid, gnt: always one-hot or zero.
// TESTING
//  1. req=3'b001, base0=100, no pause -> grant on first edge; mem_addr 100..124 over 25 cycles;
//     25 rd_valid=001 pulses starting 1 cycle later; rd_last on the 25th; gnt=0 afterwards.
//  2. req=3'b111 held, bases 0/200/400 -> bursts in order u0,u1,u2,u0; 1 idle cycle between bursts; 25 beats each.
//  3. Unit 1 bursting, pause high for 3 cycles at beat 10 -> mem_en low for 3 cycles; addr stays base+10;
//     total pulses still 25; burst length 28 cycles.
//  4. base=2^ADDR_W-5 -> addresses wrap to 0 after 16383 (ADDR_W=14); 25 beats delivered.
//  5. reset asserted at beat 12 with MEM_LATENCY=3 -> all outputs 0 in same cycle;
//     no rd_valid after release; next grant goes to unit 0.
//  6. req drops to 0 at beat 5 of unit 2's burst -> burst completes all 25 beats; FSM then IDLE, gnt=0.

Source files
------------

// File: rtl/wm_read_arbiter_if.sv
// Weight-memory read arbiter bus.
// Bundles the per-unit request/return signals and the shared memory read port.
//   req, req_base, pause : requester side -> arbiter
//   gnt, busy            : arbiter -> requesters (burst ownership)
//   mem_en, mem_addr     : arbiter -> weight memory
//   mem_rdata            : weight memory -> arbiter
//   rd_valid, rd_data, rd_last : arbiter -> requesters (tagged return data)
// Modport slave is the arbiter; modport master is the environment around it.
interface wm_read_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 14,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic                      pause;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_last;

  modport slave (
    input  req, req_base, pause, mem_rdata,
    output gnt, busy, mem_en, mem_addr, rd_valid, rd_data, rd_last
  );

  modport master (
    output req, req_base, pause, mem_rdata,
    input  gnt, busy, mem_en, mem_addr, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/wm_read_arbiter.sv
// Round-robin arbiter sharing one weight-memory read port among NUM_REQ conv
// unit control units. A granted unit receives a burst of BURST_LEN consecutive
// words starting at its captured base address; read data returns tagged to the
// owner after MEM_LATENCY cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wm_read_arbiter_if.slave (requests, memory port, return path)
module wm_read_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 25,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  wm_read_arbiter_if.slave   bus
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;

  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic                 last_beat;
  logic                 issue;

  // Return-path pipeline: stage MEM_LATENCY-1 lines up with mem_rdata.
  logic [MEM_LATENCY-1:0]              pipe_en;
  logic [MEM_LATENCY-1:0]              pipe_last;
  logic [MEM_LATENCY-1:0][NUM_REQ-1:0] pipe_own;

  // Search upward from the unit after the last winner, wrapping around.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign issue     = (state_q == BURST) && !bus.pause;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BURST;
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          last_d        = winner;
          addr_d        = bus.req_base[winner*ADDR_W +: ADDR_W];
          beat_d        = '0;
        end
      end
      BURST: begin
        if (issue) begin
          if (last_beat) begin
            state_d = IDLE;
            gnt_d   = '0;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_en   <= '0;
      pipe_last <= '0;
      pipe_own  <= '0;
    end else begin
      pipe_en[0]   <= issue;
      pipe_last[0] <= issue && last_beat;
      pipe_own[0]  <= gnt_q;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_own[i]  <= pipe_own[i-1];
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q == BURST);
  assign bus.mem_en   = issue;
  // Address only driven while a burst owns the port; wraps modulo 2^ADDR_W.
  assign bus.mem_addr = (state_q == BURST) ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign bus.rd_valid = pipe_own[MEM_LATENCY-1] & {NUM_REQ{pipe_en[MEM_LATENCY-1]}};
  assign bus.rd_last  = pipe_last[MEM_LATENCY-1] & pipe_en[MEM_LATENCY-1];
  assign bus.rd_data  = bus.mem_rdata;

endmodule

// File: tb/tb_wm_read_arbiter.sv
module tb_wm_read_arbiter;
  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BL = 25;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*AW-1:0] req_base = '0;
  logic             pause = 1'b0;

  always #5 clk = ~clk;

  wm_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_WIDTH(DW)) bus1 ();
  wm_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_WIDTH(DW)) bus3 ();

  wm_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                    .MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  wm_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                    .MEM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  assign bus1.req = req;  assign bus1.req_base = req_base;  assign bus1.pause = pause;
  assign bus3.req = req;  assign bus3.req_base = req_base;  assign bus3.pause = pause;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return {a[7:0], ~a[7:0], 2'b10, a};
  endfunction

  // Weight memory: data for an address appears MEM_LATENCY cycles later.
  logic [AW-1:0]         m1_a = '0;
  logic [2:0][AW-1:0]    m3_a = '0;
  always @(posedge clk) begin
    m1_a <= bus1.mem_addr;
    m3_a <= {m3_a[1:0], bus3.mem_addr};
  end
  assign bus1.mem_rdata = word_of(m1_a);
  assign bus3.mem_rdata = word_of(m3_a[2]);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which unit owns the port, how many words it has had,
  // and where its burst started.
  int m_owner = -1;
  int m_beat  = 0;
  int m_base  = 0;
  int m_ptr   = NR - 1;
  int cyc     = 0;
  int rst_cyc = 0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_owner = -1;
        m_beat  = 0;
        m_ptr   = NR - 1;
        rst_cyc = cyc;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= NR; k++) begin
          int u;
          u = (m_ptr + k) % NR;
          if (m_owner < 0 && req[u]) begin
            m_owner = u;
            m_ptr   = u;
            m_base  = int'(req_base[u*AW +: AW]);
            m_beat  = 0;
          end
        end
      end else if (!pause) begin
        m_beat++;
        if (m_beat == BL) begin
          m_owner = -1;
          m_beat  = 0;
        end
      end
    end
  end

  // Words issued per cycle, replayed later to predict the return path.
  bit            hv [HN];
  int            ho [HN];
  bit            hl [HN];
  logic [AW-1:0] ha [HN];

  task automatic chk_ret(input string tag, input int lat, input logic [NR-1:0] rv,
                         input logic rl, input logic [DW-1:0] rd);
    int k;
    bit v;
    logic [NR-1:0] e_rv;
    k = cyc - lat;
    v = (k >= 0) && (k > rst_cyc) && hv[k % HN];
    e_rv = v ? NR'(1 << ho[k % HN]) : '0;
    chk({tag, "_rd_valid"}, 32'(rv), 32'(e_rv));
    chk({tag, "_rd_last"}, 32'(rl), 32'(v && hl[k % HN]));
    if (v) chk({tag, "_rd_data"}, rd, word_of(ha[k % HN]));
  endtask

  // Observations used by the directed literal checks.
  int rv1_cnt [NR];
  int rv3_cnt [NR];
  int rl1_cnt, rl3_cnt, busy1_cnt;
  int gseq [$];
  int gcyc [$];
  logic [NR-1:0] prev_g = '0;

  logic [NR-1:0] e_gnt;
  logic          e_en;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    cyc++;
    e_gnt  = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    e_en   = (m_owner >= 0) && !pause;
    e_addr = (m_owner >= 0) ? AW'(m_base + m_beat) : '0;
    hv[cyc % HN] = e_en;
    ho[cyc % HN] = m_owner;
    hl[cyc % HN] = (m_beat == BL - 1);
    ha[cyc % HN] = e_addr;

    chk("d1_gnt", 32'(bus1.gnt), 32'(e_gnt));
    chk("d1_busy", 32'(bus1.busy), 32'(m_owner >= 0));
    chk("d1_mem_en", 32'(bus1.mem_en), 32'(e_en));
    chk("d1_mem_addr", 32'(bus1.mem_addr), 32'(e_addr));
    chk_ret("d1", 1, bus1.rd_valid, bus1.rd_last, bus1.rd_data);
    chk("d3_gnt", 32'(bus3.gnt), 32'(e_gnt));
    chk("d3_mem_en", 32'(bus3.mem_en), 32'(e_en));
    chk("d3_mem_addr", 32'(bus3.mem_addr), 32'(e_addr));
    chk_ret("d3", 3, bus3.rd_valid, bus3.rd_last, bus3.rd_data);

    for (int u = 0; u < NR; u++) begin
      if (bus1.rd_valid[u]) rv1_cnt[u]++;
      if (bus3.rd_valid[u]) rv3_cnt[u]++;
      if (bus1.gnt[u] && prev_g == '0) begin
        gseq.push_back(u);
        gcyc.push_back(cyc);
      end
    end
    if (bus1.rd_last) rl1_cnt++;
    if (bus3.rd_last) rl3_cnt++;
    if (bus1.busy) busy1_cnt++;
    prev_g = bus1.gnt;
  end

  task automatic clear_obs();
    for (int u = 0; u < NR; u++) begin
      rv1_cnt[u] = 0;
      rv3_cnt[u] = 0;
    end
    rl1_cnt = 0; rl3_cnt = 0; busy1_cnt = 0;
    gseq.delete();
    gcyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic set_base(input int u, input int b);
    req_base[u*AW +: AW] = AW'(b);
  endtask

  initial begin
    clear_obs();
    tick(2);
    #1;
    chk("rst_gnt", 32'(bus1.gnt), 32'd0);
    chk("rst_mem_en", 32'(bus1.mem_en), 32'd0);
    chk("rst_rd_valid", 32'(bus3.rd_valid), 32'd0);
    reset = 1'b0;
    tick(1);

    // 1: single unit, base 100
    set_base(0, 100);
    req = 3'b001;
    clear_obs();
    tick(1);
    #1;
    chk("t1_first_addr", 32'(bus1.mem_addr), 32'd100);
    chk("t1_first_gnt", 32'(bus1.gnt), 32'b001);
    chk("t1_no_early_valid", 32'(bus1.rd_valid), 32'd0);
    tick(1);
    #1;
    chk("t1_second_addr", 32'(bus1.mem_addr), 32'd101);
    chk("t1_first_valid", 32'(bus1.rd_valid), 32'b001);
    chk("t1_first_data", bus1.rd_data, word_of(14'd100));
    req = 3'b000;
    tick(30);
    chk("t1_pulses_l1", 32'(rv1_cnt[0]), 32'd25);
    chk("t1_pulses_l3", 32'(rv3_cnt[0]), 32'd25);
    chk("t1_last_l1", 32'(rl1_cnt), 32'd1);
    chk("t1_last_l3", 32'(rl3_cnt), 32'd1);
    chk("t1_gnt_after", 32'(bus1.gnt), 32'd0);

    // 2: all requesting, round-robin order
    do_reset();
    set_base(0, 0); set_base(1, 200); set_base(2, 400);
    req = 3'b111;
    clear_obs();
    for (int i = 0; i < 200 && gseq.size() < 4; i++) tick(1);
    req = 3'b000;
    tick(30);
    chk("t2_grants", 32'(gseq.size()), 32'd4);
    if (gseq.size() >= 4) begin
      chk("t2_order0", 32'(gseq[0]), 32'd0);
      chk("t2_order1", 32'(gseq[1]), 32'd1);
      chk("t2_order2", 32'(gseq[2]), 32'd2);
      chk("t2_order3", 32'(gseq[3]), 32'd0);
      chk("t2_spacing", 32'(gcyc[1] - gcyc[0]), 32'd26);
    end
    chk("t2_pulses_u0", 32'(rv1_cnt[0]), 32'd50);
    chk("t2_pulses_u1", 32'(rv1_cnt[1]), 32'd25);
    chk("t2_pulses_u2", 32'(rv3_cnt[2]), 32'd25);

    // 3: pause for 3 cycles at beat 10 of unit 1
    do_reset();
    set_base(1, 300);
    req = 3'b010;
    clear_obs();
    tick(1);
    req = 3'b000;
    tick(10);
    pause = 1'b1;
    #1;
    chk("t3_paused_en", 32'(bus1.mem_en), 32'd0);
    chk("t3_paused_addr", 32'(bus1.mem_addr), 32'd310);
    tick(3);
    pause = 1'b0;
    #1;
    chk("t3_resume_addr", 32'(bus1.mem_addr), 32'd310);
    tick(40);
    chk("t3_busy_cycles", 32'(busy1_cnt), 32'd28);
    chk("t3_pulses_l1", 32'(rv1_cnt[1]), 32'd25);
    chk("t3_pulses_l3", 32'(rv3_cnt[1]), 32'd25);

    // 4: address wrap
    do_reset();
    set_base(0, 16379);
    req = 3'b001;
    clear_obs();
    tick(1);
    req = 3'b000;
    tick(4);
    #1;
    chk("t4_top_addr", 32'(bus1.mem_addr), 32'd16383);
    tick(1);
    #1;
    chk("t4_wrap_addr", 32'(bus1.mem_addr), 32'd0);
    tick(40);
    chk("t4_pulses", 32'(rv3_cnt[0]), 32'd25);

    // 5: reset mid-burst at beat 12
    do_reset();
    set_base(1, 500);
    req = 3'b010;
    tick(1);
    req = 3'b000;
    tick(12);
    reset = 1'b1;
    clear_obs();
    #1;
    chk("t5_gnt", 32'(bus3.gnt), 32'd0);
    chk("t5_busy", 32'(bus3.busy), 32'd0);
    chk("t5_mem_en", 32'(bus3.mem_en), 32'd0);
    chk("t5_rd_valid", 32'(bus3.rd_valid), 32'd0);
    chk("t5_rd_last", 32'(bus3.rd_last), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(10);
    chk("t5_no_stale", 32'(rv3_cnt[0] + rv3_cnt[1] + rv3_cnt[2]), 32'd0);
    req = 3'b111;
    tick(1);
    #1;
    chk("t5_next_gnt", 32'(bus3.gnt), 32'b001);
    req = 3'b000;
    tick(30);

    // 6: request dropped mid-burst
    do_reset();
    set_base(2, 1000);
    req = 3'b100;
    clear_obs();
    tick(1);
    #1;
    chk("t6_gnt", 32'(bus1.gnt), 32'b100);
    tick(5);
    req = 3'b000;
    tick(19);
    #1;
    chk("t6_still_busy", 32'(bus1.busy), 32'd1);
    tick(2);
    #1;
    chk("t6_gnt_after", 32'(bus1.gnt), 32'd0);
    chk("t6_busy_after", 32'(bus1.busy), 32'd0);
    tick(10);
    chk("t6_pulses", 32'(rv1_cnt[2]), 32'd25);
    chk("t6_last", 32'(rl1_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
